// File: rtl/lsu_subword.sv
// rtl/lsu_subword.sv - sub-word load/store unit between a core and a full-width memory port
// Aligns, lane-replicates and byte-enables stores; extracts and sign/zero-extends loads.
module lsu_subword #(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DWIDTH-1:0] resp_rdata,
   output logic [1:0]        resp_err,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH/8-1:0] mem_be,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [DWIDTH-1:0] mem_rdata
);

   localparam int NB = DWIDTH / 8;
   localparam int OW = $clog2(NB);

   localparam logic [1:0] ERR_OK   = 2'd0;
   localparam logic [1:0] ERR_MIS  = 2'd1;
   localparam logic [1:0] ERR_TOUT = 2'd2;
   localparam logic [1:0] ERR_SIZE = 2'd3;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t          state;
   logic            r_we;
   logic [1:0]      r_size;
   logic            r_unsigned;
   logic [OW-1:0]   r_off;
   logic [7:0]      wait_cnt;

   logic              illegal;
   logic              misaligned;
   logic [2:0]        amask;
   logic [NB-1:0]     be_base;
   logic [NB-1:0]     be_new;
   logic [DWIDTH-1:0] wdata_new;
   logic [AWIDTH-1:0] addr_new;
   int                nbytes;

   // Decode of the incoming request; only consumed on the accept cycle.
   always_comb begin
      illegal = (req_size == 2'd3) && (DWIDTH == 32);
      amask = 3'd0;
      be_base = '0;
      case (req_size)
         2'd0: begin amask = 3'd0; be_base[0] = 1'b1; end
         2'd1: begin amask = 3'd1; be_base[1:0] = 2'b11; end
         2'd2: begin amask = 3'd3; be_base[3:0] = 4'hF; end
         default: begin amask = 3'd7; be_base = '1; end
      endcase
      misaligned = |(req_addr[2:0] & amask);
      be_new = be_base << req_addr[OW-1:0];
      addr_new = req_addr;
      addr_new[OW-1:0] = '0;
      nbytes = 1 << req_size;
      wdata_new = '0;
      for (int i = 0; i < NB; i++) begin
         wdata_new[i*8 +: 8] = req_wdata[(i % nbytes)*8 +: 8];
      end
   end

   logic [DWIDTH-1:0] shifted;
   logic [DWIDTH-1:0] ext;
   logic              sbit;
   logic              fill;
   int                nbits;

   // Load extraction: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      shifted = mem_rdata >> {r_off, 3'b000};
      nbits = 8 << r_size;
      case (r_size)
         2'd0:    sbit = shifted[7];
         2'd1:    sbit = shifted[15];
         2'd2:    sbit = shifted[31];
         default: sbit = shifted[DWIDTH-1];
      endcase
      fill = sbit & ~r_unsigned;
      ext = '0;
      for (int i = 0; i < DWIDTH; i++) begin
         ext[i] = (i < nbits) ? shifted[i] : fill;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         r_we       <= 1'b0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_off      <= '0;
         wait_cnt   <= 8'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= ERR_OK;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_off      <= req_addr[OW-1:0];
                  req_ready  <= 1'b0;
                  if (illegal) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= ERR_SIZE;
                  end else if (misaligned) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= ERR_MIS;
                  end else begin
                     state     <= REQ;
                     mem_valid <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= addr_new;
                     mem_be    <= be_new;
                     mem_wdata <= wdata_new;
                  end
               end
            end
            REQ: begin
               // mem_rvalid is deliberately not looked at here, even alongside the grant.
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_be    <= '0;
                  mem_wdata <= '0;
                  if (r_we) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= ERR_OK;
                     resp_rdata <= '0;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= 8'd0;
                  end
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_OK;
                  resp_rdata <= ext;
               end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_TOUT;
                  resp_rdata <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_err   <= ERR_OK;
               resp_rdata <= '0;
               req_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_subword.sv
// tb/tb_lsu_subword.sv - directed bench for lsu_subword, 32-bit (MAX_WAIT=4) and 64-bit instances
module tb_lsu_subword;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 32-bit instance
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size, resp_err;
   logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        resp_valid, mem_valid, mem_ready, mem_we, mem_rvalid;
   logic [3:0]  mem_be;

   // 64-bit instance
   logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
   logic [1:0]  b_req_size, b_resp_err;
   logic [31:0] b_req_addr, b_mem_addr;
   logic [63:0] b_req_wdata, b_resp_rdata, b_mem_wdata, b_mem_rdata;
   logic        b_resp_valid, b_mem_valid, b_mem_ready, b_mem_we, b_mem_rvalid;
   logic [7:0]  b_mem_be;

   lsu_subword #(.DWIDTH(32), .AWIDTH(32), .MAX_WAIT(4)) dut32 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   lsu_subword #(.DWIDTH(64), .AWIDTH(32), .MAX_WAIT(15)) dut64 (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
      .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
      .resp_err(b_resp_err), .mem_valid(b_mem_valid), .mem_ready(b_mem_ready),
      .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
      .mem_wdata(b_mem_wdata), .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req32(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      tick();
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_addr = 32'hFFFF_FFFF; req_wdata = '0;
   endtask

   task automatic load64(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [63:0] rdata, input logic [31:0] exp_addr,
                         input logic [7:0] exp_be, input logic [63:0] exp_rdata);
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = size; b_req_unsigned = uns;
      b_req_addr = addr; b_mem_ready = 1'b1;
      tick();
      b_req_valid = 1'b0;
      chk("b_mem_valid", 64'(b_mem_valid), 64'd1);
      chk("b_mem_addr", 64'(b_mem_addr), 64'(exp_addr));
      chk("b_mem_be", 64'(b_mem_be), 64'(exp_be));
      tick();
      b_mem_rvalid = 1'b1; b_mem_rdata = rdata;
      tick();
      b_mem_rvalid = 1'b0; b_mem_rdata = '0;
      chk("b_resp_valid", 64'(b_resp_valid), 64'd1);
      chk("b_resp_rdata", b_resp_rdata, exp_rdata);
      chk("b_resp_err", 64'(b_resp_err), 64'd0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_unsigned = 0; b_req_addr = 0;
      b_req_wdata = 0; b_mem_ready = 0; b_mem_rvalid = 0; b_mem_rdata = 0;
      tick(); tick();
      rst = 1'b0;

      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_mem_be", 64'(mem_be), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);

      // Signed byte load at 0x103; rvalid during the grant cycle must be ignored.
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      req32(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
      chk("ld_b_mem_valid", 64'(mem_valid), 64'd1);
      chk("ld_b_mem_addr", 64'(mem_addr), 64'h100);
      chk("ld_b_mem_be", 64'(mem_be), 64'h8);
      chk("ld_b_mem_we", 64'(mem_we), 64'd0);
      chk("ld_b_req_ready", 64'(req_ready), 64'd0);
      tick();
      chk("ld_b_grant_rvalid_ignored", 64'(resp_valid), 64'd0);
      chk("ld_b_mem_valid_off", 64'(mem_valid), 64'd0);
      mem_rdata = 32'h80FF_FFFF;
      tick();
      mem_rvalid = 1'b0; mem_rdata = '0;
      chk("ld_b_resp_valid", 64'(resp_valid), 64'd1);
      chk("ld_b_resp_rdata", 64'(resp_rdata), 64'hFFFF_FF80);
      chk("ld_b_resp_err", 64'(resp_err), 64'd0);
      tick();
      chk("ld_b_resp_one_cycle", 64'(resp_valid), 64'd0);
      chk("ld_b_ready_back", 64'(req_ready), 64'd1);

      // Byte store at 0x2 with mem_ready held low for 3 cycles.
      mem_ready = 1'b0;
      req32(1'b1, 2'd0, 1'b0, 32'h2, 32'h1234_5678);
      for (int k = 0; k < 3; k++) begin
         chk("st_mem_valid", 64'(mem_valid), 64'd1);
         chk("st_mem_we", 64'(mem_we), 64'd1);
         chk("st_mem_be", 64'(mem_be), 64'h4);
         chk("st_mem_wdata", 64'(mem_wdata), 64'h7878_7878);
         chk("st_mem_addr", 64'(mem_addr), 64'h0);
         chk("st_no_resp", 64'(resp_valid), 64'd0);
         if (k < 2) tick();
      end
      mem_ready = 1'b1;
      tick();
      chk("st_resp_valid", 64'(resp_valid), 64'd1);
      chk("st_resp_err", 64'(resp_err), 64'd0);
      chk("st_resp_rdata", 64'(resp_rdata), 64'd0);
      chk("st_mem_be_off", 64'(mem_be), 64'd0);
      tick();

      // Store latency with mem_ready tied high: 2 cycles.
      req32(1'b1, 2'd1, 1'b0, 32'h6, 32'hAAAA_BEEF);
      chk("sth_mem_be", 64'(mem_be), 64'hC);
      chk("sth_mem_wdata", 64'(mem_wdata), 64'hBEEF_BEEF);
      tick();
      chk("sth_resp_valid", 64'(resp_valid), 64'd1);
      tick();

      // Misaligned word load at 0x6: 1 cycle, no memory access.
      req32(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
      chk("mis_resp_valid", 64'(resp_valid), 64'd1);
      chk("mis_resp_err", 64'(resp_err), 64'd1);
      chk("mis_mem_valid", 64'(mem_valid), 64'd0);
      tick();

      // Dword on a 32-bit path, also misaligned: size error wins.
      req32(1'b0, 2'd3, 1'b0, 32'h1, 32'h0);
      chk("ill_resp_valid", 64'(resp_valid), 64'd1);
      chk("ill_resp_err", 64'(resp_err), 64'd3);
      chk("ill_mem_valid", 64'(mem_valid), 64'd0);
      tick();

      // Signed half load at 0x2.
      req32(1'b0, 2'd1, 1'b0, 32'h2, 32'h0);
      chk("ldh_mem_be", 64'(mem_be), 64'hC);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000;
      tick();
      mem_rvalid = 1'b0;
      chk("ldh_resp_rdata", 64'(resp_rdata), 64'hFFFF_8001);
      tick();

      // Timeout: MAX_WAIT=4, no rvalid.
      req32(1'b0, 2'd2, 1'b1, 32'h10, 32'h0);
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("tout_wait_no_resp", 64'(resp_valid), 64'd0);
      end
      tick();
      chk("tout_resp_valid", 64'(resp_valid), 64'd1);
      chk("tout_resp_err", 64'(resp_err), 64'd2);
      chk("tout_resp_rdata", 64'(resp_rdata), 64'd0);
      tick();

      // Reset while in WAIT, then a late rvalid.
      req32(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      chk("rstw_req_ready", 64'(req_ready), 64'd1);
      chk("rstw_resp_valid", 64'(resp_valid), 64'd0);
      tick();
      chk("rstw_late_rvalid_resp", 64'(resp_valid), 64'd0);
      chk("rstw_late_rvalid_ready", 64'(req_ready), 64'd1);
      mem_rvalid = 1'b0;
      tick();

      // 64-bit data path loads.
      load64(2'd1, 1'b1, 32'h206, 64'h8001_0000_0000_0000, 32'h200, 8'hC0, 64'h0000_0000_0000_8001);
      load64(2'd2, 1'b0, 32'h4, 64'h8000_0000_1234_5678, 32'h0, 8'hF0, 64'hFFFF_FFFF_8000_0000);
      load64(2'd3, 1'b0, 32'h208, 64'hDEAD_BEEF_0000_0001, 32'h208, 8'hFF, 64'hDEAD_BEEF_0000_0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_subword.md
LSU_SUBWORD -- requirements
Module: lsu_subword

Interface
REQ-001 Parameter DWIDTH, default 32, meaning data-path width in bits; legal values 32 or 64.
REQ-002 Parameter AWIDTH, default 32, meaning byte-address width.
REQ-003 Parameter MAX_WAIT, default 15, meaning the maximum number of cycles in WAIT before a load times out; legal range 1..255.
REQ-004 Derived constants: NB = DWIDTH/8, the byte lanes; OW = log2(NB), the offset bits.
REQ-005 clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  meaning reset; synchronous, active-high.
REQ-007 req_valid  input  1  meaning the core presents an access.
REQ-008 req_ready  output  1  meaning the unit accepts an access; a transfer occurs when req_valid and req_ready are both high.
REQ-009 req_we  input  1  meaning 1 = store, 0 = load.
REQ-010 req_size  input  2  meaning 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-011 req_unsigned  input  1  meaning zero-extend on load (1) or sign-extend (0).
REQ-012 req_addr  input  AWIDTH  meaning the byte address.
REQ-013 req_wdata  input  DWIDTH  meaning store data, right-aligned.
REQ-014 resp_valid  output  1  meaning a one-cycle completion pulse.
REQ-015 resp_rdata  output  DWIDTH  meaning extended load data; 0 for stores and errors.
REQ-016 resp_err  output  2  meaning 0 = ok, 1 = misaligned, 2 = timeout, 3 = illegal size.
REQ-017 mem_valid  output  1  meaning a memory request is presented.
REQ-018 mem_ready  input  1  meaning memory accepts the request.
REQ-019 mem_we  output  1  meaning a memory write.
REQ-020 mem_addr  output  AWIDTH  meaning the request address with bits [OW-1:0] forced to 0.
REQ-021 mem_be  output  NB  meaning byte enables.
REQ-022 mem_wdata  output  DWIDTH  meaning lane-replicated store data.
REQ-023 mem_rvalid  input  1  meaning load data is valid.
REQ-024 mem_rdata  input  DWIDTH  meaning full-width load data.

Function
REQ-025 The FSM SHALL have the states IDLE, REQ, WAIT and RESP.
REQ-026 req_ready SHALL be 1 only in IDLE, and the accepted request fields SHALL be registered on the accept cycle; inputs are ignored in all other states.
REQ-027 Illegal-size check: size 3 with DWIDTH=32 SHALL go IDLE->RESP with resp_err=3 and no memory access.
REQ-028 Misalignment check: an address not aligned to 2^size bytes SHALL go IDLE->RESP with resp_err=1 and no memory access; the illegal-size check takes priority.
REQ-029 Otherwise the FSM SHALL go IDLE->REQ.
REQ-030 In REQ, mem_valid SHALL be 1 and mem_addr, mem_we, mem_be and mem_wdata SHALL be held stable until mem_ready is high.
REQ-031 In REQ with mem_ready high, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-032 mem_rvalid in the same cycle as mem_ready SHALL be ignored; load data is taken in WAIT only.
REQ-033 In WAIT, mem_rvalid high SHALL capture the extracted data and go to RESP.
REQ-034 A wait counter SHALL be cleared on entry to WAIT and increment each WAIT cycle without mem_rvalid; when it reaches MAX_WAIT the FSM SHALL go to RESP with resp_err=2 and resp_rdata=0.
REQ-035 RESP SHALL last exactly one cycle with resp_valid=1 and SHALL then return to IDLE.
REQ-036 Minimum latency SHALL be: store with mem_ready tied high, accept to resp_valid = 2 cycles; load with rvalid one cycle after the grant = 3 cycles; an error = 1 cycle.
REQ-037 mem_be SHALL be ((1<<2^size)-1) << addr[OW-1:0], and 0 whenever mem_valid=0.
REQ-038 mem_wdata SHALL be the low 2^size bytes of req_wdata replicated across all lanes.
REQ-039 Load extraction SHALL select bytes starting at lane addr[OW-1:0].
REQ-040 The extracted data SHALL be extended to DWIDTH from its own top bit; all bits above the access width SHALL be filled, sign or zero per req_unsigned.
REQ-041 All outputs not named active in a state SHALL be 0.

Reset
REQ-042 rst SHALL force IDLE, clear the wait counter and the registered request, and drive req_ready=1 with resp_valid=0, resp_err=0, resp_rdata=0, mem_valid=0, mem_we=0, mem_be=0, mem_addr=0 and mem_wdata=0 in the following cycle.
REQ-043 rst asserted in REQ or WAIT SHALL abandon the access with no resp_valid; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-044 Load, DWIDTH=32, byte signed, addr 0x103, mem_rdata 0x80FFFFFF -> mem_addr 0x100, mem_be 4'b1000, resp_rdata 0xFFFFFF80, err 0.
REQ-045 Load, DWIDTH=64, half unsigned, addr 0x206, mem_rdata 0x8001_0000_0000_0000 -> mem_be 8'hC0, resp_rdata 0x0000_0000_0000_8001.
REQ-046 Store, DWIDTH=32, byte, addr 0x2, wdata 0x12345678 -> mem_be 4'b0100, mem_wdata 0x78787878; mem_ready delayed 3 cycles -> the request is held stable and resp_valid arrives 1 cycle after the grant.
REQ-047 Word load at addr 0x6 -> resp_err 1 one cycle after accept with mem_valid never high; dword with DWIDTH=32 -> resp_err 3.
REQ-048 MAX_WAIT=4 with no mem_rvalid -> resp_err 2 after 4 WAIT cycles; rst in WAIT -> IDLE with no resp_valid.
